au_seq_mult: RTL and testbench
==============================

AU_SEQ_MULT -- requirements
Module: au_seq_mult

Interface
REQ-001 The block SHALL have no parameters; operand width SHALL be fixed at 4 bits and product width at 8 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 a  input  4  unsigned multiplicand; sampled with start.
REQ-006 b  input  4  unsigned multiplier; sampled with start.
REQ-007 ready  output  1  high when in IDLE and able to accept start.
REQ-008 busy  output  1  high in RUN.
REQ-009 done  output  1  one-cycle pulse marking product valid.
REQ-010 product  output  8  unsigned a*b; held until the next accepted start.

Function
REQ-011 The block SHALL be an FSM with states IDLE, RUN, and DONE.
REQ-012 In IDLE, start=1 at a rising edge SHALL latch the operands: M<=a, Q<=b, A<=0, C<=0, cnt<=0, state<=RUN.
REQ-013 Each RUN edge SHALL:
- compute {C,A} = A + (Q[0] ? M : 0) with a 4-bit carry-lookahead add (generate/propagate, all carries computed in parallel);
- then shift {C,A,Q} right by one;
- then increment cnt.
REQ-014 After the 4th RUN edge (cnt reaching 4), state SHALL go to DONE and product SHALL be loaded with {A,Q}.
REQ-015 done SHALL be high for exactly the one cycle spent in DONE; DONE SHALL return to IDLE unconditionally on the next edge.
REQ-016 Latency: with start captured at edge E, done SHALL be high in the cycle following edge E+4; the next start SHALL be accepted no earlier than edge E+6.
REQ-017 start SHALL be ignored in RUN and DONE; operand changes after capture SHALL not affect the result.
REQ-018 If start is held high continuously, consecutive multiplies SHALL be accepted back-to-back, one every 6 cycles.
REQ-019 ready SHALL equal (state==IDLE); busy SHALL equal (state==RUN); done and busy SHALL never be high together.
REQ-020 The product SHALL be exact for all 256 operand pairs; the maximum, 15*15=225, SHALL use the C bit with no overflow loss.

Reset
REQ-021 rst_n=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, product=0, done=0, busy=0, ready=1, and clear M, Q, A, C, and cnt.
REQ-022 Reset asserted in RUN or DONE SHALL abort the operation with no done pulse; the first edge after deassertion SHALL behave as in IDLE.

Configuration
REQ-023 Macro AU_MULT_ZERO_SKIP_EN:
- When defined, a start accepted with a==0 or b==0 SHALL go directly IDLE->DONE with product=0, giving done in the cycle after the capture edge (latency 1).
- When undefined, every multiply SHALL take the full 4 RUN cycles regardless of operand values.

Verification
REQ-024 a=15, b=15, start pulse -> done high 4 edges after capture, product=0xE1 (225); busy high for exactly 4 cycles.
REQ-025 a=7, b=3, then a=0x9, b=0xA back-to-back with start held high -> product=21, then product=90; done pulses spaced 6 cycles apart.
REQ-026 a=0, b=9: with AU_MULT_ZERO_SKIP_EN -> done 1 cycle after capture, product=0; without it -> done after 4 RUN cycles, product=0.
REQ-027 Accept a=5, b=6, then pulse start with a=15, b=15 and toggle a/b during RUN -> product=30; the second start is ignored.
REQ-028 Assert rst_n=0 asynchronously mid-cycle in the 2nd RUN cycle -> outputs clear without a clock edge, no done pulse; then a=12, b=11 -> product=132.
REQ-029 Exhaustive sweep of all 256 a,b pairs against a reference model -> zero mismatches, one done pulse per start.

Source files
------------

// File: rtl/au_seq_mult.sv
// au_seq_mult: 4x4 unsigned sequential shift-and-add multiplier (IDLE/RUN/DONE).
// The partial-product add is a 4-bit carry-lookahead adder; one multiplier bit
// is retired per RUN cycle, so a full multiply takes 4 RUN cycles.
//
// Ports:
//   clk      in   1  rising-edge clock
//   rst_n    in   1  asynchronous active-low reset
//   start    in   1  begin a multiply (sampled only in IDLE)
//   a        in   4  unsigned multiplicand (captured with start)
//   b        in   4  unsigned multiplier (captured with start)
//   ready    out  1  in IDLE, able to accept start
//   busy     out  1  in RUN
//   done     out  1  one-cycle pulse, product valid
//   product  out  8  a*b, held until the next completed multiply
//
// Optional feature: define AU_MULT_ZERO_SKIP_EN to send a start with a zero
// operand straight from IDLE to DONE with product 0.
module au_seq_mult (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic [7:0] product
);

  localparam int unsigned OP_W   = 4;
  localparam int unsigned PROD_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OP_W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [OP_W-1:0]     r_m, w_m_nxt;
  logic [OP_W-1:0]     r_q, w_q_nxt;
  logic [OP_W-1:0]     r_a, w_a_nxt;
  logic                r_c, w_c_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [PROD_W-1:0]   r_product, w_product_nxt;
  logic                r_ready, r_busy, r_done;

  // Carry-lookahead add of the gated multiplicand into the accumulator.
  // C is always 0 after a shift, so it serves as the adder carry-in.
  logic [OP_W-1:0]     w_addend, w_g, w_p, w_sum;
  logic                w_c0, w_c1, w_c2, w_c3, w_cout;
  logic [2*OP_W:0]     w_shift;
  logic [CNT_W-1:0]    w_cnt_inc;

  always_comb begin
    w_addend = r_q[0] ? r_m : '0;
    w_g      = r_a & w_addend;
    w_p      = r_a ^ w_addend;
    w_c0     = r_c;
    w_c1     = w_g[0] | (w_p[0] & w_c0);
    w_c2     = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c0);
    w_c3     = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
             | (w_p[2] & w_p[1] & w_p[0] & w_c0);
    w_cout   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
             | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
             | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c0);
    w_sum    = w_p ^ {w_c3, w_c2, w_c1, w_c0};
    // {C,A,Q} shifted right once; the carry lands in A[3].
    w_shift  = {w_cout, w_sum, r_q} >> 1;
    w_cnt_inc = r_cnt + CNT_W'(1);
  end

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt   = r_state;
    w_m_nxt       = r_m;
    w_q_nxt       = r_q;
    w_a_nxt       = r_a;
    w_c_nxt       = r_c;
    w_cnt_nxt     = r_cnt;
    w_product_nxt = r_product;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_m_nxt   = a;
          w_q_nxt   = b;
          w_a_nxt   = '0;
          w_c_nxt   = 1'b0;
          w_cnt_nxt = '0;
`ifdef AU_MULT_ZERO_SKIP_EN
          if ((a == '0) || (b == '0)) begin
            w_state_nxt   = DONE;
            w_product_nxt = '0;
          end else begin
            w_state_nxt = RUN;
          end
`else
          w_state_nxt = RUN;
`endif
        end
      end
      RUN: begin
        w_c_nxt   = w_shift[2*OP_W];
        w_a_nxt   = w_shift[2*OP_W-1:OP_W];
        w_q_nxt   = w_shift[OP_W-1:0];
        w_cnt_nxt = w_cnt_inc;
        if (w_cnt_inc == LAST_CNT) begin
          w_state_nxt   = DONE;
          w_product_nxt = w_shift[PROD_W-1:0];
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, datapath and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_m       <= '0;
      r_q       <= '0;
      r_a       <= '0;
      r_c       <= 1'b0;
      r_cnt     <= '0;
      r_product <= '0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_m       <= w_m_nxt;
      r_q       <= w_q_nxt;
      r_a       <= w_a_nxt;
      r_c       <= w_c_nxt;
      r_cnt     <= w_cnt_nxt;
      r_product <= w_product_nxt;
      r_ready   <= (w_state_nxt == IDLE);
      r_busy    <= (w_state_nxt == RUN);
      r_done    <= (w_state_nxt == DONE);
    end
  end

  assign ready   = r_ready;
  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_au_seq_mult.sv
// Directed testbench for au_seq_mult: reset, corner products, back-to-back
// starts, ignored starts, asynchronous abort and a full 16x16 operand sweep.
module tb_au_seq_mult;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       ready;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_overlap = 0;

  au_seq_mult dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (done && busy) n_overlap <= n_overlap + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Capture edges between the capture edge and the edge that enters DONE.
  function automatic int exp_lat(input int ta, input int tb);
`ifdef AU_MULT_ZERO_SKIP_EN
    if ((ta == 0) || (tb == 0)) return 0;
`endif
    return 4;
  endfunction

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
  endtask

  // One full multiply: checks product, latency, busy length and single done.
  task automatic run_mult(input int ta, input int tb, input int exp_p, input string tag);
    int  n;
    int  nb;
    bit  seen;
    int  lat;
    lat = exp_lat(ta, tb);
    @(negedge clk);
    check_eq({tag, "_ready"}, 32'(ready), 32'd1);
    start = 1'b1;
    a     = 4'(ta);
    b     = 4'(tb);
    @(posedge clk);
    n = 0; nb = 0; seen = 1'b0;
    while (n < 20 && !seen) begin
      @(negedge clk);
      if (n == 0) start = 1'b0;
      if (busy) nb++;
      if (done) seen = 1'b1;
      else begin
        @(posedge clk);
        n++;
      end
    end
    check_eq({tag, "_seen"},    32'(seen),    32'd1);
    check_eq({tag, "_lat"},     32'(n),       32'(lat));
    check_eq({tag, "_busy"},    32'(nb),      32'(lat));
    check_eq({tag, "_product"}, 32'(product), 32'(exp_p));
    @(negedge clk);
    check_eq({tag, "_single"},  32'({done, ready}), 32'b01);
  endtask

  initial begin
    bit seen;
    int t0, t1, t2, nd, nbz;
    rst_n = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #1 rst_n = 1'b0;
    #10;
    check_eq("rst_ready",   32'(ready),   32'd1);
    check_eq("rst_busy",    32'(busy),    32'd0);
    check_eq("rst_done",    32'(done),    32'd0);
    check_eq("rst_product", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_mult(15, 15, 225, "max");

    // Back-to-back with start held high; operands change after first capture.
    @(negedge clk);
    start = 1'b1; a = 4'd7; b = 4'd3;
    @(posedge clk);
    @(negedge clk);
    t0 = cyc;
    a = 4'd9; b = 4'd10;
    wait_done(seen);
    t1 = cyc;
    check_eq("b2b_first_seen", 32'(seen),    32'd1);
    check_eq("b2b_first_prod", 32'(product), 32'd21);
    check_eq("b2b_first_lat",  32'(t1 - t0), 32'd4);
    wait_done(seen);
    t2 = cyc;
    start = 1'b0;
    check_eq("b2b_second_seen", 32'(seen),    32'd1);
    check_eq("b2b_second_prod", 32'(product), 32'd90);
    check_eq("b2b_spacing",     32'(t2 - t1), 32'd6);

    run_mult(0, 9, 0, "zero_a");
    run_mult(9, 0, 0, "zero_b");

    // Start pulse and operand toggling during RUN must be ignored.
    @(negedge clk);
    start = 1'b1; a = 4'd5; b = 4'd6;
    @(posedge clk);
    @(negedge clk);
    start = 1'b1; a = 4'd15; b = 4'd15;
    @(negedge clk);
    start = 1'b0; a = 4'd9; b = 4'd3;
    @(negedge clk);
    a = 4'd2; b = 4'd14;
    wait_done(seen);
    check_eq("ign_seen",    32'(seen),    32'd1);
    check_eq("ign_product", 32'(product), 32'd30);
    nd = 0; nbz = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) nd++;
      if (busy) nbz++;
    end
    check_eq("ign_no_done", 32'(nd),  32'd0);
    check_eq("ign_no_busy", 32'(nbz), 32'd0);

    // Asynchronous reset in the second RUN cycle aborts the multiply.
    @(negedge clk);
    start = 1'b1; a = 4'd3; b = 4'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("abort_ready",   32'(ready),   32'd1);
    check_eq("abort_busy",    32'(busy),    32'd0);
    check_eq("abort_done",    32'(done),    32'd0);
    check_eq("abort_product", 32'(product), 32'd0);
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check_eq("abort_no_done", 32'(nd), 32'd0);
    rst_n = 1'b1;
    run_mult(12, 11, 132, "post_abort");

    // Full operand sweep against a*b computed here.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        run_mult(ia, ib, ia * ib, $sformatf("sweep_%0d_%0d", ia, ib));
      end
    end

    check_eq("done_busy_overlap", 32'(n_overlap), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
